entropy_collector: RTL and testbench
====================================

Name: entropy_collector

Overview:
- Consumer end of the `entropy_valid`/`entropy_bit` stream produced by the RNG sources (hardware or mock).
- Applies optional von Neumann debiasing to the raw bits.
- Runs a repetition-count health test on the raw stream.
- Packs the conditioned bits into WIDTH-bit words and delivers them over a valid/ready handshake to downstream logic (output mux, user readout).

Parameters:
- WIDTH, 8: output word width in bits (≥2).
- REP_LIMIT, 16: raw run length of identical bits that trips the health test (2..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entropy_valid  input  1  raw bit qualifier; a sample is taken on each rising edge where it is 1.
- entropy_bit  input  1  raw entropy bit.
- out_ready  input  1  downstream accepts out_word this cycle.
- out_valid  output  1  out_word holds an unconsumed word.
- out_word  output  WIDTH  assembled word.
- health_fail  output  1  sticky: repetition test tripped.
- overrun  output  1  sticky: a conditioned bit was dropped for lack of space.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_word=0, health_fail=0, overrun=0, shifter=0, bit count=0, pair-half flag=0, run length=0, last raw bit=0. Reset mid-word discards the partial word and any held word.
- Raw sample: taken when entropy_valid=1 at a rising edge. With entropy_valid=0, no internal state changes except handshake consumption.
- Debias (VON_NEUMANN_EN defined):
  - First bit of a pair is stored and the pair-half flag is set.
  - On the second bit, the flag clears.
  - Pair 01 emits 0; pair 10 emits 1 (emitted bit = first bit); pairs 00 and 11 emit nothing.
  - Pairing starts with the first sample after reset.
- Shifter:
  - Each emitted bit shifts in left-to-right: word <= {word[WIDTH-2:0], bit}. The first bit ends up as MSB.
  - The count increments; count is 0..WIDTH.
- Transfer condition: count==WIDTH (or reaches WIDTH this edge) and the output slot is free. The slot is free when out_valid=0, or out_valid=1 and out_ready=1 this edge.
- Transfer action, on the same edge: out_word <= completed word, out_valid <= 1, count <= 0.
  - Latency: out_valid is high the cycle after the edge that samples the completing bit.
- Hold/stall: if the slot is not free, the shifter keeps the full word (count=WIDTH).
  - Every further emitted bit is dropped and overrun <= 1 (sticky).
  - The transfer happens on the first edge the slot frees.
- Handshake:
  - A word is consumed on an edge with out_valid=1 and out_ready=1.
  - out_valid falls next cycle unless a simultaneous transfer refills the slot; in that case it stays 1 with the new word.
  - out_word is stable while out_valid=1 and out_ready=0.
- Health test, on raw samples regardless of debias:
  - If the sample equals the last raw bit, run length increments, saturating at REP_LIMIT; otherwise run length <= 1. The first sample after reset sets run length to 1.
  - When run length reaches REP_LIMIT, health_fail <= 1 on that same edge. It is sticky until reset.
- Once health_fail=1:
  - out_valid <= 0; any held word is discarded.
  - Shifter and count are cleared; no further words are produced.
  - Raw sampling and run counting may continue but have no visible effect.
  - overrun no longer changes.
- Simultaneous health trip and transfer on one edge: the health trip wins, and out_valid=0 after the edge.

Optional Feature:
- VON_NEUMANN_EN
- Defined: debias stage as above.
- Undefined: every raw sample feeds the shifter directly; no pair-half flag. Health test, handshake and overrun are unchanged.

Test Plan:
- Debias on, out_ready=1: feed raw 1,0,1,0,0,1,1,1,1,0,1,1,1,1,1,1 twice (32 valid cycles) → exactly one word, out_word=0xDD, out_valid high one cycle; health_fail=0, overrun=0.
- Debias on, alternating 0,1 continuous, out_ready=1 → a 0x00 word every 16 valid samples; health_fail stays 0.
- Debias on, out_ready=0, raw 1,0 repeated 17 pairs → first 0xFF in out_word, second 0xFF held in the shifter, overrun=1 after the 17th pair. Then raise out_ready for 1 cycle → out_word=0xFF again, out_valid stays 1.
- Constant entropy_bit=1, REP_LIMIT=16 → health_fail=1 after the 16th valid edge and never earlier. out_valid stays 0 thereafter, even with alternating input.
- Debias off, raw 1,0,1,1,0,0,1,0, out_ready=1 → out_word=0xB2, out_valid=1 the cycle after the 8th sample.
- Feed 5 raw bits, assert rst_n=0 mid-cycle (asynchronous), release, then feed a full word → all outputs 0 immediately on reset, and the next word contains only post-reset bits.

Source files
------------

// File: rtl/entropy_collector.sv
// entropy_collector
//   Consumer end of the raw entropy_valid/entropy_bit stream. Optionally
//   debiases the raw bits (von Neumann), runs a repetition-count health test
//   on the raw samples, packs conditioned bits MSB-first into WIDTH-bit words
//   and hands them downstream over a valid/ready handshake.
//
//   Build option: define VON_NEUMANN_EN to enable the von Neumann debias
//   stage. Without it every raw sample feeds the shifter directly.
//
// Parameters
//   WIDTH      output word width in bits (>= 2)
//   REP_LIMIT  raw run length of identical bits that trips the health test
//              (2..255)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   entropy_valid  raw bit qualifier, one sample per edge where high
//   entropy_bit    raw entropy bit
//   out_ready      downstream accepts out_word this cycle
//   out_valid      out_word holds an unconsumed word
//   out_word       assembled word (first conditioned bit is the MSB)
//   health_fail    sticky: repetition test tripped
//   overrun        sticky: a conditioned bit was dropped for lack of space
module entropy_collector #(
    parameter int WIDTH     = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entropy_valid,
    input  logic             entropy_bit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word,
    output logic             health_fail,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = 8;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(REP_LIMIT);

    logic [WIDTH-1:0] shifter, shifter_n;
    logic [CW-1:0]    count, count_n;
    logic [RW-1:0]    run_len, run_len_n;
    logic             last_bit;
    logic             out_valid_n, overrun_n, health_n;
    logic [WIDTH-1:0] out_word_n;
    logic [WIDTH-1:0] shifted;
    logic             emit, emit_bit;
    logic             slot_free, full, trip;

    // ------------------------------------------------------------------
    // Conditioning stage: decides whether this edge produces a bit.
    // ------------------------------------------------------------------
`ifdef VON_NEUMANN_EN
    logic half;       // first bit of a pair is held
    logic first_bit;  // the held first bit

    // 01 -> 0, 10 -> 1 (the first bit); 00 and 11 are discarded.
    assign emit     = entropy_valid && half && (first_bit != entropy_bit);
    assign emit_bit = first_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half      <= 1'b0;
            first_bit <= 1'b0;
        end else if (entropy_valid) begin
            half <= ~half;
            if (!half) first_bit <= entropy_bit;
        end
    end
`else
    assign emit     = entropy_valid;
    assign emit_bit = entropy_bit;
`endif

    // ------------------------------------------------------------------
    // Repetition-count health test on the raw samples.
    // run_len==0 only right after reset, so the first sample always
    // starts a fresh run of 1 regardless of the reset value of last_bit.
    // ------------------------------------------------------------------
    always_comb begin
        run_len_n = run_len;
        if (entropy_valid) begin
            if (run_len != '0 && entropy_bit == last_bit)
                run_len_n = (run_len == RUN_MAX) ? run_len : run_len + RW'(1);
            else
                run_len_n = RW'(1);
        end
    end

    assign trip     = entropy_valid && (run_len_n == RUN_MAX);
    assign health_n = health_fail | trip;

    // ------------------------------------------------------------------
    // Shifter, output slot and overrun.
    // ------------------------------------------------------------------
    assign slot_free = !out_valid || out_ready;
    assign full      = (count == CNT_FULL);
    assign shifted   = {shifter[WIDTH-2:0], emit_bit};

    always_comb begin
        shifter_n   = shifter;
        count_n     = count;
        overrun_n   = overrun;
        out_word_n  = out_word;
        out_valid_n = out_valid && !out_ready;

        if (full) begin
            if (slot_free) begin
                // Held word moves out; a bit arriving on the same edge
                // starts the next word rather than being lost.
                out_valid_n = 1'b1;
                out_word_n  = shifter;
                if (emit) begin
                    shifter_n = {{(WIDTH-1){1'b0}}, emit_bit};
                    count_n   = CW'(1);
                end else begin
                    shifter_n = '0;
                    count_n   = '0;
                end
            end else if (emit) begin
                overrun_n = 1'b1;
            end
        end else if (emit) begin
            if (count == CNT_LAST && slot_free) begin
                out_valid_n = 1'b1;
                out_word_n  = shifted;
                shifter_n   = '0;
                count_n     = '0;
            end else begin
                shifter_n = shifted;
                count_n   = count + CW'(1);
            end
        end

        // A failed health test kills the datapath; it beats a same-edge
        // transfer and freezes overrun and out_word.
        if (health_n) begin
            out_valid_n = 1'b0;
            out_word_n  = out_word;
            shifter_n   = '0;
            count_n     = '0;
            overrun_n   = overrun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter     <= '0;
            count       <= '0;
            run_len     <= '0;
            last_bit    <= 1'b0;
            out_valid   <= 1'b0;
            out_word    <= '0;
            health_fail <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            shifter     <= shifter_n;
            count       <= count_n;
            run_len     <= run_len_n;
            out_valid   <= out_valid_n;
            out_word    <= out_word_n;
            health_fail <= health_n;
            overrun     <= overrun_n;
            if (entropy_valid) last_bit <= entropy_bit;
        end
    end

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector (WIDTH=8, REP_LIMIT=16). Works in
// either build; the conditioned-bit helper sends a "b, ~b" raw pair per
// conditioned bit when VON_NEUMANN_EN is defined, which emits exactly b.
module tb_entropy_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entropy_valid = 1'b0;
    logic       entropy_bit = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_word;
    logic       health_fail;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    logic [7:0] last_word = '0;

    entropy_collector #(.WIDTH(8), .REP_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .entropy_valid(entropy_valid), .entropy_bit(entropy_bit),
        .out_ready(out_ready), .out_valid(out_valid), .out_word(out_word),
        .health_fail(health_fail), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given raw inputs; outputs sampled 1ns after the edge.
    task automatic step(input logic v, input logic b);
        entropy_valid = v;
        entropy_bit   = b;
        @(posedge clk);
        #1;
        entropy_valid = 1'b0;
        if (out_valid) begin
            nvalid++;
            last_word = out_word;
        end
    endtask

    task automatic send_bit(input logic b);
`ifdef VON_NEUMANN_EN
        step(1'b1, b);
        step(1'b1, ~b);
`else
        step(1'b1, b);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        entropy_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nvalid = 0;
        last_word = '0;
    endtask

    logic [7:0] pat;
`ifdef VON_NEUMANN_EN
    logic [15:0] raw16;
`endif

    initial begin
        // Reset state, before any clock edge.
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_word", 32'(out_word), 0);
        chk("rst_hf", 32'(health_fail), 0);
        chk("rst_ov", 32'(overrun), 0);
        do_reset();

        // Single word with latency check: 0xB2.
        out_ready = 1'b1;
        pat = 8'hB2;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        chk("b2_early", 32'(out_valid), 0);
        send_bit(pat[0]);
        chk("b2_valid", 32'(out_valid), 1);
        chk("b2_word", 32'(out_word), 32'hB2);
        step(1'b0, 1'b0);
        chk("b2_consumed", 32'(out_valid), 0);

`ifdef VON_NEUMANN_EN
        // Raw debias sequence twice -> single 0xDD word.
        do_reset();
        out_ready = 1'b1;
        raw16 = 16'b1010011110111111;
        for (int r = 0; r < 2; r++)
            for (int i = 15; i >= 0; i--) step(1'b1, raw16[i]);
        step(1'b0, 1'b0);
        chk("dd_count", 32'(nvalid), 1);
        chk("dd_word", 32'(last_word), 32'hDD);
        chk("dd_hf", 32'(health_fail), 0);
        chk("dd_ov", 32'(overrun), 0);

        // Alternating 0,1 -> 0x00 word every 16 raw samples.
        do_reset();
        out_ready = 1'b1;
        last_word = 8'hFF;
        for (int i = 0; i < 48; i++) step(1'b1, 1'(i & 1));
        step(1'b0, 1'b0);
        chk("alt_count", 32'(nvalid), 3);
        chk("alt_word", 32'(last_word), 0);
        chk("alt_hf", 32'(health_fail), 0);
`endif

        // Stall: first word out, second held, 17th bit overruns.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'(~i & 1));
        chk("stall_v1", 32'(out_valid), 1);
        chk("stall_w1", 32'(out_word), 32'hAA);
        for (int i = 0; i < 8; i++) send_bit(1'(~i & 1));
        chk("stall_ov16", 32'(overrun), 0);
        chk("stall_hold_word", 32'(out_word), 32'hAA);
        send_bit(1'b1);
        chk("stall_ov17", 32'(overrun), 1);
        out_ready = 1'b1;
        step(1'b0, 1'b0);
        out_ready = 1'b0;
        chk("refill_valid", 32'(out_valid), 1);
        chk("refill_word", 32'(out_word), 32'hAA);
        out_ready = 1'b1;
        step(1'b0, 1'b0);
        chk("drain_valid", 32'(out_valid), 0);
        chk("ov_sticky", 32'(overrun), 1);

        // Repetition test: trips on the 16th identical sample, not before.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
        chk("hf_15", 32'(health_fail), 0);
        step(1'b1, 1'b1);
        chk("hf_16", 32'(health_fail), 1);
        chk("hf_valid", 32'(out_valid), 0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'(i & 1));
        chk("hf_no_words", 32'(nvalid), 0);
        chk("hf_sticky", 32'(health_fail), 1);
        chk("hf_ov", 32'(overrun), 0);

        // Asynchronous reset mid-word discards held and partial words.
        do_reset();
        out_ready = 1'b0;
        pat = 8'hB3;
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        for (int i = 0; i < 5; i++) send_bit(1'(~i & 1));
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_word", 32'(out_word), 0);
        chk("async_hf", 32'(health_fail), 0);
        chk("async_ov", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        pat = 8'h69;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        chk("post_rst_early", 32'(out_valid), 0);
        send_bit(pat[0]);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_word", 32'(out_word), 32'h69);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
